// File: rtl/dc_arb_pkg.sv
// rtl/dc_arb_pkg.sv - shared state encoding and AXI read attribute constants for the read arbiter
package dc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dc_rr_arbiter.sv
// rtl/dc_rr_arbiter.sv - combinational rotating-priority pick starting just after rr_ptr
module dc_rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [IDX_WIDTH-1:0] winner,
  output logic                 valid
);

  logic [IDX_WIDTH-1:0] cand;

  // Scan from the farthest offset down so the nearest requester after rr_ptr wins last
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_WIDTH'((int'(rr_ptr) + off) % NUM_REQ);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dc_axi_read_arbiter.sv
// rtl/dc_axi_read_arbiter.sv - round-robin AXI4 read port share, one burst in flight; optional DC_ARB_BEAT_CHECK_EN beat checker
module dc_axi_read_arbiter
  import dc_arb_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int REQ_IDX_WIDTH    = 1,
  parameter int AXI_ARADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [NUM_REQ-1:0]                req_arvalid,
  input  logic [NUM_REQ*AXI_ARADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]              req_arlen,
  output logic [NUM_REQ-1:0]                req_arready,
  output logic [NUM_REQ-1:0]                req_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]         req_rdata,
  output logic                              req_rlast,
  input  logic [NUM_REQ-1:0]                req_rready,
  output logic [7:0]                        axi_arid,
  output logic [AXI_ARADDR_WIDTH-1:0]       axi_araddr,
  output logic [7:0]                        axi_arlen,
  output logic [2:0]                        axi_arsize,
  output logic [1:0]                        axi_arburst,
  output logic [1:0]                        axi_arlock,
  output logic [3:0]                        axi_arcache,
  output logic [2:0]                        axi_arprot,
  output logic [3:0]                        axi_arqos,
  output logic [3:0]                        axi_arregion,
  output logic                              axi_arvalid,
  input  logic                              axi_arready,
  input  logic [7:0]                        axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]         axi_rdata,
  input  logic [1:0]                        axi_rresp,
  input  logic                              axi_rlast,
  input  logic                              axi_rvalid,
  output logic                              axi_rready,
  output logic                              busy,
  output logic [REQ_IDX_WIDTH-1:0]          grant_idx,
  output logic                              err_resp,
  output logic                              err_len
);

  arb_state_e                  state_q, state_d;
  logic [REQ_IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [REQ_IDX_WIDTH-1:0]    grant_q, grant_d;
  logic [AXI_ARADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                  arlen_q, arlen_d;
  logic                        err_resp_q, err_resp_d;
  logic [REQ_IDX_WIDTH-1:0]    win_idx;
  logic                        win_vld;
  logic                        beat;

  dc_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_rr (
    .req    (req_arvalid),
    .rr_ptr (rr_ptr_q),
    .winner (win_idx),
    .valid  (win_vld)
  );

  assign beat = (state_q == DATA) && axi_rvalid && req_rready[grant_q];

  // State and captured-request registers; rr_ptr starts at the top so requester 0 goes first
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= REQ_IDX_WIDTH'(NUM_REQ - 1);
      grant_q    <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      err_resp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      err_resp_q <= err_resp_d;
    end
  end

  // Next state: capture the winner in IDLE, wait for the slave in ADDR, retire on rlast in DATA
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    err_resp_d = err_resp_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = ADDR;
          grant_d  = win_idx;
          araddr_d = req_araddr[int'(win_idx)*AXI_ARADDR_WIDTH +: AXI_ARADDR_WIDTH];
          arlen_d  = req_arlen[int'(win_idx)*8 +: 8];
        end
      end
      ADDR: begin
        if (axi_arready) state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          if (axi_rresp != AXI_RESP_OKAY) err_resp_d = 1'b1;
          if (axi_rlast) begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake steering: only the owning requester sees ready/valid; data bus is zero outside DATA
  always_comb begin
    req_arready = '0;
    req_rvalid  = '0;
    req_rdata   = '0;
    req_rlast   = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) req_arready[win_idx] = 1'b1;
      end
      ADDR: axi_arvalid = 1'b1;
      DATA: begin
        axi_rready          = req_rready[grant_q];
        req_rvalid[grant_q] = axi_rvalid;
        req_rdata           = axi_rdata;
        req_rlast           = axi_rlast;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign grant_idx    = grant_q;
  assign err_resp     = err_resp_q;
  assign axi_arid     = 8'(grant_q);
  assign axi_araddr   = araddr_q;
  assign axi_arlen    = arlen_q;
  assign axi_arsize   = AXI_SIZE_2B;
  assign axi_arburst  = AXI_BURST_INCR;
  assign axi_arlock   = 2'b00;
  assign axi_arcache  = AXI_CACHE_DEF;
  assign axi_arprot   = 3'b000;
  assign axi_arqos    = 4'b0000;
  assign axi_arregion = 4'b0000;

`ifdef DC_ARB_BEAT_CHECK_EN
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       err_len_q, err_len_d;

  // Beat counter holds beats already taken; rlast must coincide with the arlen-th count and rid with the grant
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_len_d  = err_len_q;
    if (state_q == IDLE && win_vld) begin
      beat_cnt_d = '0;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
      if (axi_rlast != (beat_cnt_q == arlen_q)) err_len_d = 1'b1;
      if (axi_rid != 8'(grant_q)) err_len_d = 1'b1;
    end
  end

  // Beat-check registers, sticky error cleared only by reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      beat_cnt_q <= '0;
      err_len_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_len_q  <= err_len_d;
    end
  end

  assign err_len = err_len_q;
`else
  logic unused_rid;
  assign unused_rid = ^axi_rid;
  assign err_len    = 1'b0;
`endif

endmodule
